// File: rtl/reflet_timer_bank.sv
// Bank of independent down-counting timers behind a four-register-per-channel window.
// Each channel: prescaler, reload, count, one-shot/periodic mode and a level interrupt flag.
module reflet_timer_bank #(
  parameter int word_size = 16,
  parameter int channels  = 4,
  parameter int addr_size = $clog2(channels) + 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [addr_size-1:0] addr,
  input  logic [word_size-1:0] data_in,
  input  logic                 write_en,
  output logic [word_size-1:0] data_out,
  output logic [channels-1:0]  interrupt
);

  logic [channels-1:0]  enable;
  logic [channels-1:0]  periodic;
  logic [channels-1:0]  irq_en;
  logic [channels-1:0]  flag;
  logic [word_size-1:0] prescale [channels];
  logic [word_size-1:0] reload   [channels];
  logic [word_size-1:0] count    [channels];
  logic [word_size-1:0] pc       [channels];

  logic [addr_size-1:0] sel_chan;
  logic [1:0]           sel_reg;
  logic                 sel_valid;
  logic [channels-1:0]  hit;
  logic [channels-1:0]  tick;
  logic [channels-1:0]  expire;
  logic [word_size-1:0] rd_data;

  // Shifting keeps the decode legal when there is only one channel (no channel field).
  assign sel_chan  = addr >> 2;
  assign sel_reg   = addr[1:0];
  assign sel_valid = {{(32-addr_size){1'b0}}, sel_chan} < 32'(channels);

  assign interrupt = flag & irq_en;

  always_comb begin
    hit    = '0;
    tick   = '0;
    expire = '0;
    for (int i = 0; i < channels; i++) begin
      hit[i]    = write_en && sel_valid && (sel_chan == addr_size'(i));
      tick[i]   = enable[i] && (pc[i] == prescale[i]);
      expire[i] = tick[i] && (count[i] == '0);
    end
  end

  always_comb begin
    rd_data = '0;
    if (sel_valid) begin
      for (int i = 0; i < channels; i++) begin
        if (sel_chan == addr_size'(i)) begin
          case (sel_reg)
            2'd0: rd_data[3:0] = {flag[i], irq_en[i], periodic[i], enable[i]};
            2'd1: rd_data = prescale[i];
            2'd2: rd_data = reload[i];
            default: rd_data = count[i];
          endcase
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      enable   <= '0;
      periodic <= '0;
      irq_en   <= '0;
      flag     <= '0;
      data_out <= '0;
      for (int i = 0; i < channels; i++) begin
        prescale[i] <= '0;
        reload[i]   <= '0;
        count[i]    <= '0;
        pc[i]       <= '0;
      end
    end else begin
      data_out <= rd_data;
      for (int i = 0; i < channels; i++) begin
        // A config write always decides enable, so it overrides a one-shot expiry.
        if (hit[i] && sel_reg == 2'd0) begin
          enable[i]   <= data_in[0];
          periodic[i] <= data_in[1];
          irq_en[i]   <= data_in[2];
        end else if (expire[i] && !periodic[i]) begin
          enable[i] <= 1'b0;
        end

        if (expire[i])
          flag[i] <= 1'b1;
        else if (hit[i] && sel_reg == 2'd0 && data_in[3])
          flag[i] <= 1'b0;

        if ((hit[i] && sel_reg == 2'd0) || !enable[i] || tick[i])
          pc[i] <= '0;
        else
          pc[i] <= pc[i] + 1'b1;

        if (hit[i] && sel_reg == 2'd1)
          prescale[i] <= data_in;
        if (hit[i] && sel_reg == 2'd2)
          reload[i] <= data_in;

        if (hit[i] && sel_reg == 2'd3)
          count[i] <= data_in;
        else if (tick[i]) begin
          if (count[i] == '0)
            count[i] <= periodic[i] ? reload[i] : '0;
          else
            count[i] <= count[i] - 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_reflet_timer_bank.sv
// Directed bench for reflet_timer_bank: reset, periodic, prescaler, one-shot,
// collision, channel independence and out-of-range decode.
module tb_reflet_timer_bank;
  // Five channels so that channel select 5 is addressable yet out of range.
  localparam int WS = 16;
  localparam int CH = 5;
  localparam int AW = $clog2(CH) + 2;

  logic          clk = 1'b0;
  logic          reset;
  logic [AW-1:0] addr;
  logic [WS-1:0] data_in;
  logic          write_en;
  logic [WS-1:0] data_out;
  logic [CH-1:0] interrupt;

  int checks   = 0;
  int failures = 0;

  reflet_timer_bank #(.word_size(WS), .channels(CH)) dut (
    .clk       (clk),
    .reset     (reset),
    .addr      (addr),
    .data_in   (data_in),
    .write_en  (write_en),
    .data_out  (data_out),
    .interrupt (interrupt)
  );

  always #5 clk = ~clk;

  function automatic logic [AW-1:0] a_of(input int ch, input int rg);
    return AW'(ch * 4 + rg);
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int ch, input int rg, input logic [WS-1:0] v);
    addr     = a_of(ch, rg);
    data_in  = v;
    write_en = 1'b1;
    step();
    write_en = 1'b0;
  endtask

  task automatic rd_check(input string tag, input int ch, input int rg, input logic [WS-1:0] exp);
    addr = a_of(ch, rg);
    step();
    check(tag, 32'(data_out), 32'(exp));
  endtask

  initial begin
    reset    = 1'b1;
    write_en = 1'b0;
    addr     = '0;
    data_in  = '0;
    step();
    step();
    check("rst_data", 32'(data_out), 0);
    check("rst_irq", 32'(interrupt), 0);
    reset = 1'b0;

    // Periodic ch0: P=0, R=3, C=3 -> count 3,2,1,0 then expiry every 4 cycles.
    wr(0, 1, 0);
    wr(0, 2, 3);
    wr(0, 3, 3);
    wr(0, 0, 7);
    addr = a_of(0, 3);
    for (int k = 1; k <= 4; k++) begin
      step();
      check("per_count", 32'(data_out), 32'(4 - k));
      check("per_irq", 32'(interrupt[0]), 32'(k == 4));
    end
    wr(0, 0, 16'hF);
    check("w1c_pre_read", 32'(data_out), 32'hF);
    check("w1c_irq", 32'(interrupt[0]), 0);
    addr = a_of(0, 3);
    step();
    check("per_count_after_w1c", 32'(data_out), 2);
    step();
    step();
    check("per_reassert", 32'(interrupt[0]), 1);
    check("per_count_zero", 32'(data_out), 0);
    step();
    step();
    step();
    wr(0, 0, 16'hF);
    check("w1c_vs_expiry", 32'(interrupt[0]), 1);
    wr(0, 3, 7);
    step();
    check("cwrite_vs_tick", 32'(data_out), 7);
    wr(0, 0, 16'h8);
    check("ch0_stop", 32'(interrupt[0]), 0);

    // Prescaler ch1: P=4, R=1, C=1 -> interrupt 10 cycles after enable.
    wr(1, 1, 4);
    wr(1, 2, 1);
    wr(1, 3, 1);
    wr(1, 0, 7);
    addr = a_of(1, 3);
    for (int k = 1; k <= 10; k++) begin
      step();
      if (k == 6) check("pre_count_first_tick", 32'(data_out), 0);
      check("pre_irq", 32'(interrupt[1]), 32'(k == 10));
    end
    step();
    check("pre_reload", 32'(data_out), 1);
    wr(1, 0, 16'h8);
    check("ch1_stop", 32'(interrupt[1]), 0);

    // One-shot ch2: P=0, C=2 -> flag after 3 ticks, then disabled at 0.
    wr(2, 3, 2);
    wr(2, 0, 5);
    step();
    step();
    check("os_irq_early", 32'(interrupt[2]), 0);
    step();
    check("os_irq", 32'(interrupt[2]), 1);
    rd_check("os_cfg", 2, 0, 16'hC);
    addr = a_of(2, 3);
    step();
    step();
    check("os_count_hold", 32'(data_out), 0);
    wr(2, 0, 16'h8);

    // Independence: ch0 R=1, ch3 R=2; clear ch3 without touching ch0.
    wr(0, 2, 1);
    wr(0, 3, 1);
    wr(0, 0, 7);
    wr(3, 1, 0);
    wr(3, 2, 2);
    wr(3, 3, 2);
    wr(3, 0, 7);
    step();
    step();
    step();
    check("indep_both", 32'(interrupt), 32'h09);
    wr(3, 0, 16'hF);
    check("indep_clear_ch3", 32'(interrupt), 32'h01);

    // Out-of-range channel select.
    wr(5, 2, 16'hABCD);
    wr(5, 3, 16'h1234);
    rd_check("oor_read", 5, 2, 0);
    rd_check("oor_no_alias_r", 1, 2, 1);
    rd_check("oor_no_alias_c", 1, 3, 1);

    // Reset with live state.
    reset = 1'b1;
    step();
    step();
    check("rst2_irq", 32'(interrupt), 0);
    check("rst2_data", 32'(data_out), 0);
    reset = 1'b0;
    rd_check("rst2_cfg0", 0, 0, 0);
    rd_check("rst2_r3", 3, 2, 0);
    rd_check("rst2_c0", 0, 3, 0);
    rd_check("rst2_p1", 1, 1, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
